// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, call-stack depth and the mux selects
// that route the stack top into the PC and register-load paths.
package cpu_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned STACK_DEPTH = 16;

  localparam logic [1:0] PCMUX_STACK = 2'b10;
  localparam logic [1:0] MUX1_STACK  = 2'b11;

endpackage : cpu_pkg

// File: rtl/stack_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately left unreset.
module stack_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : stack_mem

// File: rtl/call_stack.sv
// Hardware LIFO for call/return and register save. Top-of-stack is readable
// combinationally in the same cycle as the pop strobe; state commits on the edge.
module call_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = STACK_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic [WIDTH-1:0] push_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pop_data,
  output logic             stack_full,
  output logic             stack_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] rd_data;
  logic             new_ovf, new_unf;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CW'(DEPTH));
  // Power-of-two depth: count == DEPTH aliases to index 0, so top is DEPTH-1.
  assign top_idx     = count_q[AW-1:0] - AW'(1);

  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    new_ovf = 1'b0;
    new_unf = 1'b0;
    unique case ({push_en, pop_en})
      2'b10: begin
        if (stack_full) begin
          new_ovf = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (stack_empty) begin
          new_unf = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      2'b11: begin
        we = 1'b1;
        if (stack_empty) begin
          waddr   = '0;
          count_d = CW'(1);
          new_unf = 1'b1;
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
    // A fresh error event in the same cycle beats the clear.
    ovf_d = new_ovf | (ovf_q & ~err_clr);
    unf_d = new_unf | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(push_data),
    .raddr_i(top_idx),
    .rdata_o(rd_data)
  );

  assign pop_data  = stack_empty ? '0 : rd_data;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule : call_stack
